// File: rtl/sprint_input_pkg.sv
// rtl/sprint_input_pkg.sv - shared types and constants for Sprint 1 input conditioning
package sprint_input_pkg;

    localparam int PEND_W   = 10;
    localparam int PEND_MAX = 255;

    typedef logic signed [PEND_W-1:0] pend_t;

    localparam pend_t PEND_SAT_HI = pend_t'(PEND_MAX);
    localparam pend_t PEND_SAT_LO = pend_t'(-PEND_MAX);

    // Quadrature output indexed by phase; adjacent entries differ in one bit.
    localparam logic [1:0] QUAD_GRAY [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    typedef enum logic [1:0] {
        STEP_NONE  = 2'd0,
        STEP_RIGHT = 2'd1,
        STEP_LEFT  = 2'd2
    } step_e;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler emitting a one-cycle strobe every CLKDIV cycles
module tick_gen #(
    parameter int CLKDIV = 22500
) (
    input  logic clk_sys,
    input  logic reset,
    output logic tick
);

    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(CLKDIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/steer_quad_tracker.sv
// rtl/steer_quad_tracker.sv - digital/analog steering intent to two-phase quadrature for the Sprint 1 core
module steer_quad_tracker
    import sprint_input_pkg::*;
#(
    parameter int CLKDIV   = 22500,
    parameter int PEND_W   = sprint_input_pkg::PEND_W,
    parameter int PEND_MAX = sprint_input_pkg::PEND_MAX
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     left,
    input  logic                     right,
    input  logic                     analog_en,
    input  logic [7:0]               analog_x,
    output logic [1:0]               steer,
    output logic signed [PEND_W-1:0] pending,
    output logic                     tick
);

    localparam int SW = PEND_W + 2;
    localparam logic signed [SW-1:0] SUM_HI = SW'(PEND_MAX);
    localparam logic signed [SW-1:0] SUM_LO = SW'(-PEND_MAX);

    logic [1:0]               phase_q, phase_d;
    logic [1:0]               steer_q, steer_d;
    logic signed [PEND_W-1:0] pending_q, pending_d;
    logic [7:0]               prev_x_q, prev_x_d;
    logic                     armed_q, armed_d;

    step_e                    step;
    logic [1:0]               consume;
    logic [8:0]               delta;
    logic signed [SW-1:0]     sum;

    tick_gen #(.CLKDIV(CLKDIV)) u_tick_gen (
        .clk_sys (clk_sys),
        .reset   (reset),
        .tick    (tick)
    );

    always_comb begin
        step    = STEP_NONE;
        consume = 2'b00;
        if (tick) begin
            if (left ^ right) begin
                step = right ? STEP_RIGHT : STEP_LEFT;
            end else if (!left && !right) begin
                if (!pending_q[PEND_W-1] && (pending_q != '0)) begin
                    step    = STEP_RIGHT;
                    consume = 2'b01;
                end else if (pending_q[PEND_W-1]) begin
                    step    = STEP_LEFT;
                    consume = 2'b11;
                end
            end
        end

        case (step)
            STEP_RIGHT: phase_d = phase_q + 2'd1;
            STEP_LEFT:  phase_d = phase_q - 2'd1;
            default:    phase_d = phase_q;
        endcase
        steer_d = QUAD_GRAY[phase_d];
    end

    // Axis tracking: the first sample after enable only arms, so no jump is taken on enable.
    always_comb begin
        armed_d  = armed_q;
        prev_x_d = prev_x_q;
        delta    = '0;
        if (!analog_en) begin
            armed_d = 1'b0;
        end else if (!armed_q) begin
            armed_d  = 1'b1;
            prev_x_d = analog_x;
        end else begin
            delta    = {analog_x[7], analog_x} - {prev_x_q[7], prev_x_q};
            prev_x_d = analog_x;
        end
    end

    always_comb begin
        sum = {{2{pending_q[PEND_W-1]}}, pending_q}
            + {{(SW-9){delta[8]}}, delta}
            - {{(SW-2){consume[1]}}, consume};
        if (sum > SUM_HI) begin
            pending_d = SUM_HI[PEND_W-1:0];
        end else if (sum < SUM_LO) begin
            pending_d = SUM_LO[PEND_W-1:0];
        end else begin
            pending_d = sum[PEND_W-1:0];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            phase_q   <= 2'd0;
            steer_q   <= 2'b00;
            pending_q <= '0;
            prev_x_q  <= '0;
            armed_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            steer_q   <= steer_d;
            pending_q <= pending_d;
            prev_x_q  <= prev_x_d;
            armed_q   <= armed_d;
        end
    end

    assign steer   = steer_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_steer_quad_tracker.sv
// tb/tb_steer_quad_tracker.sv - scoreboard bench for steer_quad_tracker
module tb_steer_quad_tracker;

    localparam int CLKDIV = 4;

    logic              clk_sys;
    logic              reset;
    logic              left;
    logic              right;
    logic              analog_en;
    logic [7:0]        analog_x;
    logic [1:0]        steer;
    logic signed [9:0] pending;
    logic              tick;

    int         n_checks;
    int         n_errors;
    logic [1:0] exp_q[$];
    logic [1:0] last_steer;
    logic [1:0] exp_val;
    logic       prev_tick;
    int         gap;

    steer_quad_tracker #(
        .CLKDIV   (CLKDIV),
        .PEND_W   (10),
        .PEND_MAX (255)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .left      (left),
        .right     (right),
        .analog_en (analog_en),
        .analog_x  (analog_x),
        .steer     (steer),
        .pending   (pending),
        .tick      (tick)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Monitor: pops an expected steer value on every observed transition.
    always @(posedge clk_sys) begin
        #1;
        if (reset) begin
            last_steer = steer;
            prev_tick  = 1'b0;
            gap        = 1;
        end else begin
            gap++;
            if (tick) begin
                n_checks++;
                if (gap != CLKDIV) begin
                    n_errors++;
                    $display("FAIL tick_period: got %0d cycles, expected %0d", gap, CLKDIV);
                end
                gap = 0;
            end
            if (steer !== last_steer) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_step: steer went %b -> %b, expected no change", last_steer, steer);
                end else begin
                    exp_val = exp_q.pop_front();
                    if (steer !== exp_val) begin
                        n_errors++;
                        $display("FAIL steer_seq: got %b, expected %b", steer, exp_val);
                    end
                end
                n_checks++;
                if ($countones(steer ^ last_steer) != 1) begin
                    n_errors++;
                    $display("FAIL one_bit_change: got %b -> %b, expected single-bit change", last_steer, steer);
                end
                n_checks++;
                if (!prev_tick) begin
                    n_errors++;
                    $display("FAIL step_latency: steer changed to %b without a tick in the prior cycle, expected tick=1", steer);
                end
                last_steer = steer;
            end
            prev_tick = tick;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_tick();
        int w;
        w = 0;
        do begin
            @(negedge clk_sys);
            w++;
        end while (!tick && w < 3 * CLKDIV);
        if (!tick) begin
            n_checks++;
            n_errors++;
            $display("FAIL tick_timeout: got no tick in %0d cycles, expected one", w);
        end
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            wait_tick();
            @(negedge clk_sys);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        left      = 1'b0;
        right     = 1'b0;
        analog_en = 1'b0;
        analog_x  = 8'h00;
        repeat (3) @(negedge clk_sys);
        chk("reset_steer", int'(steer), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_tick", int'(tick), 0);
        reset = 1'b0;

        run_ticks(5);
        chk("idle_steer", int'(steer), 0);
        chk("idle_pending", int'(pending), 0);

        right = 1'b1;
        exp_q.push_back(2'b01); exp_q.push_back(2'b11);
        exp_q.push_back(2'b10); exp_q.push_back(2'b00);
        run_ticks(4);
        right = 1'b0;

        left = 1'b1;
        exp_q.push_back(2'b10); exp_q.push_back(2'b11);
        exp_q.push_back(2'b01); exp_q.push_back(2'b00);
        run_ticks(4);
        left = 1'b0;

        left = 1'b1; right = 1'b1;
        run_ticks(3);
        left = 1'b0; right = 1'b0;
        run_ticks(1);
        chk("both_held_steer", int'(steer), 0);

        analog_en = 1'b1; analog_x = 8'd40;
        @(negedge clk_sys);
        chk("arm_pending", int'(pending), 0);
        analog_x = 8'd45;
        @(negedge clk_sys);
        chk("delta_pending", int'(pending), 5);
        exp_q.push_back(2'b01); exp_q.push_back(2'b11); exp_q.push_back(2'b10);
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        run_ticks(5);
        chk("drain_pending", int'(pending), 0);
        chk("drain_steer", int'(steer), 1);

        left = 1'b1; right = 1'b1; analog_en = 1'b0;
        @(negedge clk_sys);
        for (int k = 0; k < 3; k++) begin
            analog_en = 1'b1; analog_x = 8'h7F;
            @(negedge clk_sys);
            analog_x = 8'h80;
            @(negedge clk_sys);
            analog_en = 1'b0;
            @(negedge clk_sys);
            if (k == 0) chk("sweep1_pending", int'(pending), -255);
        end
        chk("sat_pending", int'(pending), -255);
        run_ticks(2);
        chk("sat_hold_pending", int'(pending), -255);

        analog_en = 1'b1; analog_x = 8'd0;
        @(negedge clk_sys);
        wait_tick();
        left = 1'b0; right = 1'b0; analog_x = 8'd10;
        exp_q.push_back(2'b00);
        @(negedge clk_sys);
        left = 1'b1; right = 1'b1;
        chk("tick_delta_pending", int'(pending), -244);

        reset = 1'b1; analog_en = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0; analog_en = 1'b1; analog_x = 8'd0;
        @(negedge clk_sys);
        analog_x = 8'd7;
        @(negedge clk_sys);
        chk("pend7_pending", int'(pending), 7);
        left = 1'b0;
        exp_q.push_back(2'b01); exp_q.push_back(2'b11);
        run_ticks(2);
        left = 1'b1;
        chk("right_keep_pending", int'(pending), 7);
        chk("right_keep_steer", int'(steer), 3);

        reset = 1'b1;
        @(negedge clk_sys);
        chk("midrst_steer", int'(steer), 0);
        chk("midrst_pending", int'(pending), 0);
        chk("midrst_tick", int'(tick), 0);
        reset = 1'b0; left = 1'b0; right = 1'b0; analog_en = 1'b0;
        run_ticks(2);
        chk("post_reset_steer", int'(steer), 0);
        chk("exp_queue_empty", exp_q.size(), 0);

        repeat (2) @(negedge clk_sys);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
